// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-outstanding AXI slave bridging to a synchronous single-port SRAM.
// Reads take two cycles per beat (fetch, then data); writes go straight through on W beats.
// Optional feature: define AXI_SRAM_BURST_CHECK_EN to answer non-INCR bursts with SLVERR
// and suppress their SRAM accesses. Default build treats every burst as INCR.
module axi_sram_slave #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [7:0]        AWID,
    input  logic [31:0]       AWADDR,
    input  logic [3:0]        AWLEN,
    input  logic [2:0]        AWSIZE,
    input  logic [1:0]        AWBURST,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [31:0]       WDATA,
    input  logic [3:0]        WSTRB,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [7:0]        BID,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [7:0]        ARID,
    input  logic [31:0]       ARADDR,
    input  logic [3:0]        ARLEN,
    input  logic [2:0]        ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [7:0]        RID,
    output logic [31:0]       RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              CS,
    output logic              OE,
    output logic [3:0]        WEB,
    output logic [ADDR_W-1:0] A,
    output logic [31:0]       DI,
    input  logic [31:0]       DO
);
    typedef enum logic [2:0] {IDLE, R_FETCH, R_DATA, W_DATA, B_RESP} state_e;

    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;
    localparam logic [ADDR_W-1:0] ADDR_ONE    = 1;

    state_e            state_q, state_d;
    logic [7:0]        id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        len_q, len_d;
    // One bit wider than LEN so an over-long write burst still shows up as a count mismatch.
    logic [4:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    // Set for the first R_DATA cycle, while DO is live and not yet captured.
    logic              fresh_q, fresh_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              ar_bad, aw_bad;
    logic              unused_bits;

`ifdef AXI_SRAM_BURST_CHECK_EN
    assign ar_bad = (ARBURST != 2'b01);
    assign aw_bad = (AWBURST != 2'b01);
    assign unused_bits = ^{AWSIZE, ARSIZE, AWADDR[31:ADDR_W+2], AWADDR[1:0],
                           ARADDR[31:ADDR_W+2], ARADDR[1:0]};
`else
    assign ar_bad = 1'b0;
    assign aw_bad = 1'b0;
    assign unused_bits = ^{AWSIZE, ARSIZE, AWBURST, ARBURST, AWADDR[31:ADDR_W+2], AWADDR[1:0],
                           ARADDR[31:ADDR_W+2], ARADDR[1:0]};
`endif

    // State and captured transaction fields; reset abandons any burst in flight.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            fresh_q <= 1'b0;
            rdata_q <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fresh_q <= fresh_d;
            rdata_q <= rdata_d;
            bresp_q <= bresp_d;
        end
    end

    // Next-state, AXI handshake outputs and SRAM strobes.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fresh_d = 1'b0;
        rdata_d = rdata_q;
        bresp_d = bresp_q;
        ARREADY = 1'b0;
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        RVALID  = 1'b0;
        RLAST   = 1'b0;
        RRESP   = RESP_OKAY;
        BVALID  = 1'b0;
        CS      = 1'b0;
        OE      = 1'b0;
        WEB     = 4'hF;
        DI      = '0;
        A       = addr_q;
        RID     = id_q;
        BID     = id_q;
        BRESP   = bresp_q;
        RDATA   = fresh_q ? DO : rdata_q;
        unique case (state_q)
            IDLE: begin
                // Readiness held low while reset is asserted; reads win a same-cycle tie.
                ARREADY = ARESETn;
                AWREADY = ARESETn & ~ARVALID;
                if (ARVALID) begin
                    id_d    = ARID;
                    addr_d  = ARADDR[ADDR_W+1:2];
                    len_d   = ARLEN;
                    cnt_d   = '0;
                    err_d   = ar_bad;
                    state_d = R_FETCH;
                end else if (AWVALID) begin
                    id_d    = AWID;
                    addr_d  = AWADDR[ADDR_W+1:2];
                    len_d   = AWLEN;
                    cnt_d   = '0;
                    err_d   = aw_bad;
                    bresp_d = RESP_OKAY;
                    state_d = W_DATA;
                end
            end
            R_FETCH: begin
                CS      = ~err_q;
                OE      = ~err_q;
                fresh_d = 1'b1;
                state_d = R_DATA;
            end
            R_DATA: begin
                RVALID = 1'b1;
                RLAST  = (cnt_q == {1'b0, len_q});
                RRESP  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (fresh_q) begin
                    rdata_d = DO;
                end
                if (RREADY) begin
                    if (RLAST) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        cnt_d   = cnt_q + 5'd1;
                        state_d = R_FETCH;
                    end
                end
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (WVALID) begin
                    CS     = ~err_q;
                    WEB    = err_q ? 4'hF : ~WSTRB;
                    DI     = WDATA;
                    addr_d = addr_q + ADDR_ONE;
                    cnt_d  = cnt_q + 5'd1;
                    if (WLAST) begin
                        bresp_d = (err_q || (cnt_q != {1'b0, len_q})) ? RESP_SLVERR : RESP_OKAY;
                        state_d = B_RESP;
                    end
                end
            end
            B_RESP: begin
                BVALID = 1'b1;
                if (BREADY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed bench with an SRAM model, a reference memory and queues of
// expected SRAM cycles / R beats / B responses, checked every cycle by one compare process.
module tb_axi_sram_slave;
    logic        ACLK, ARESETn;
    logic [7:0]  AWID, ARID, BID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA, DI, DO;
    logic [3:0]  AWLEN, ARLEN, WSTRB, WEB;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY, CS, OE;
    logic [13:0] A;

`ifdef AXI_SRAM_BURST_CHECK_EN
    localparam bit BurstCheck = 1'b1;
`else
    localparam bit BurstCheck = 1'b0;
`endif

    axi_sram_slave #(.ADDR_W(14)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY),
        .CS(CS), .OE(OE), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
    );

    typedef struct packed {logic we; logic [13:0] a; logic [3:0] web; logic [31:0] d;} sram_t;
    typedef struct packed {
        logic [7:0] id; logic [31:0] data; logic last; logic [1:0] resp; logic chk_data;
    } rbeat_t;
    typedef struct packed {logic [7:0] id; logic [1:0] resp;} b_t;

    sram_t       exp_sram[$];
    rbeat_t      exp_r[$];
    b_t          exp_b[$];
    logic [31:0] rd_log[$];

    logic [31:0] mem [0:16383];
    bit          mem_wr [0:16383];
    bit [31:0]   ref_mem [0:16383];
    bit          ref_wr [0:16383];

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          aw_cyc = 0;
    int          rlast_cyc = 0;
    int          n_rlast = 0;
    logic [13:0] last_fetch_a = '0;
    logic [7:0]  last_bid = '0;
    logic [1:0]  last_bresp = '0;
    logic [1:0]  last_rresp = '0;
    bit          hold_v = 0;
    logic [40:0] held = '0;

    function automatic logic [31:0] pat(input logic [13:0] a);
        return 32'hC0DE0000 | {18'h0, a};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] en);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (en[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [13:0] a);
        return ref_wr[a] ? ref_mem[a] : pat(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial forever begin
        @(posedge ACLK);
        cyc++;
    end

    // SRAM model: read data valid the cycle after CS&OE, garbage otherwise.
    initial begin
        DO = '0;
        forever begin
            @(posedge ACLK);
            if (CS && OE) DO <= mem_wr[A] ? mem[A] : pat(A);
            else DO <= $urandom;
            if (CS && !OE) begin
                mem[A]    <= merge(mem_wr[A] ? mem[A] : pat(A), DI, ~WEB);
                mem_wr[A] <= 1'b1;
            end
        end
    end

    // Compare process: DUT outputs against the expectation queues on every falling edge.
    initial forever begin
        sram_t  s;
        rbeat_t rb;
        b_t     bb;
        @(negedge ACLK);
        if (!ARESETn) begin
            hold_v = 0;
        end else begin
            if (CS) begin
                if (exp_sram.size() == 0) begin
                    chk("sram_unexpected", 64'(CS), 64'd0);
                end else begin
                    s = exp_sram.pop_front();
                    chk("sram_ctl", 64'({OE, A, WEB}), 64'({~s.we, s.a, s.web}));
                    if (s.we) chk("sram_di", 64'(DI), 64'(s.d));
                    else last_fetch_a = A;
                end
            end else begin
                chk("sram_idle", 64'({OE, WEB}), 64'({1'b0, 4'hF}));
            end
            if (RVALID) begin
                if (hold_v) chk("r_hold", 64'({RID, RLAST, RDATA}), 64'(held));
                if (RREADY) begin
                    hold_v = 0;
                    if (exp_r.size() == 0) begin
                        chk("r_unexpected", 64'(RVALID), 64'd0);
                    end else begin
                        rb = exp_r.pop_front();
                        chk("r_id", 64'(RID), 64'(rb.id));
                        chk("r_resp", 64'(RRESP), 64'(rb.resp));
                        chk("r_last", 64'(RLAST), 64'(rb.last));
                        if (rb.chk_data) chk("r_data", 64'(RDATA), 64'(rb.data));
                    end
                    rd_log.push_back(RDATA);
                    last_rresp = RRESP;
                    if (RLAST) begin
                        n_rlast++;
                        rlast_cyc = cyc;
                    end
                end else begin
                    hold_v = 1;
                    held   = {RID, RLAST, RDATA};
                end
            end else if (hold_v) begin
                chk("r_valid_dropped", 64'(RVALID), 64'd1);
                hold_v = 0;
            end
            if (BVALID && BREADY) begin
                if (exp_b.size() == 0) begin
                    chk("b_unexpected", 64'(BVALID), 64'd0);
                end else begin
                    bb = exp_b.pop_front();
                    chk("b_id", 64'(BID), 64'(bb.id));
                    chk("b_resp", 64'(BRESP), 64'(bb.resp));
                end
                last_bid   = BID;
                last_bresp = BRESP;
            end
            if (AWVALID && AWREADY) begin
                chk("aw_not_with_ar", 64'(ARVALID), 64'd0);
                aw_cyc = cyc;
            end
        end
    end

    task automatic wait_ready(input int ch, input string name);
        bit ok = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge ACLK);
            ok = (ch == 0 && AWREADY) || (ch == 1 && ARREADY) || (ch == 2 && WREADY);
        end
        if (!ok) chk(name, 64'd0, 64'd1);
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_rvalid(input string name);
        bit ok = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge ACLK);
            ok = RVALID;
        end
        if (!ok) chk(name, 64'd0, 64'd1);
    endtask

    task automatic wait_drain(input string name);
        bit ok = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge ACLK);
            ok = (exp_r.size() == 0) && (exp_b.size() == 0) && (exp_sram.size() == 0);
        end
        if (!ok) begin
            chk(name, 64'd0, 64'd1);
            exp_r.delete();
            exp_b.delete();
            exp_sram.delete();
        end
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input int nbeats, input logic [31:0] d0,
                            input logic [3:0] strb);
        logic [13:0] wa = addr[15:2];
        bit          err = BurstCheck && (burst != 2'b01);
        sram_t       s;
        b_t          bb;
        AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWSIZE = 3'd2; AWVALID = 1'b1;
        wait_ready(0, "aw_timeout");
        AWVALID = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            WDATA  = d0 + 32'(i) * 32'h01010101;
            WSTRB  = strb;
            WLAST  = (i == nbeats - 1);
            WVALID = 1'b1;
            if (!err) begin
                s.we = 1'b1; s.a = wa + 14'(i); s.web = ~strb; s.d = WDATA;
                exp_sram.push_back(s);
                ref_mem[s.a] = merge(ref_read(s.a), WDATA, strb);
                ref_wr[s.a]  = 1'b1;
            end
            wait_ready(2, "w_timeout");
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        bb.id   = id;
        bb.resp = (err || nbeats != int'(len) + 1) ? 2'b10 : 2'b00;
        exp_b.push_back(bb);
        wait_drain("write_drain_timeout");
    endtask

    task automatic push_read_exp(input logic [7:0] id, input logic [13:0] wa, input logic [3:0] len,
                                 input bit err);
        sram_t  s;
        rbeat_t rb;
        for (int i = 0; i <= int'(len); i++) begin
            if (!err) begin
                s.we = 1'b0; s.a = wa + 14'(i); s.web = 4'hF; s.d = '0;
                exp_sram.push_back(s);
            end
            rb.id = id; rb.data = ref_read(wa + 14'(i)); rb.last = (i == int'(len));
            rb.resp = err ? 2'b10 : 2'b00; rb.chk_data = !err;
            exp_r.push_back(rb);
        end
    endtask

    task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input bit stall);
        push_read_exp(id, addr[15:2], len, BurstCheck && (burst != 2'b01));
        if (stall) RREADY = 1'b0;
        ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARSIZE = 3'd2; ARVALID = 1'b1;
        wait_ready(1, "ar_timeout");
        ARVALID = 1'b0;
        if (stall) begin
            wait_rvalid("rvalid_timeout");
            repeat (5) @(posedge ACLK);
            #1;
            RREADY = 1'b1;
        end
        wait_drain("read_drain_timeout");
    endtask

    initial begin
        ARESETn = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b0;
        RREADY = 1'b1;
        #12;
        chk("rst_outputs", 64'({RVALID, BVALID, WREADY, ARREADY, AWREADY, CS, OE, WEB}),
            64'({7'b0, 4'hF}));
        chk("rst_data", 64'({RDATA, RRESP, BRESP}), 64'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;
        chk("idle_ready", 64'({ARREADY, AWREADY}), 64'b11);

        // Single full-word write.
        do_write(8'h12, 32'h100, 4'd0, 2'b01, 1, 32'hDEADBEEF, 4'hF);
        chk("w1_bid", 64'(last_bid), 64'h12);
        chk("w1_bresp", 64'(last_bresp), 64'd0);
        chk("w1_sram", 64'(mem[14'h40]), 64'hDEADBEEF);

        // Two-beat write with byte strobes 0101.
        do_write(8'h13, 32'h104, 4'd1, 2'b01, 2, 32'h11223344, 4'b0101);
        chk("w2_bresp", 64'(last_bresp), 64'd0);

        // Four-beat INCR read across the written words.
        rd_log.delete();
        n_rlast = 0;
        do_read(8'h21, 32'h100, 4'd3, 2'b01, 1'b0);
        chk("r1_beats", 64'(rd_log.size()), 64'd4);
        chk("r1_beat0", 64'(rd_log[0]), 64'hDEADBEEF);
        chk("r1_beat1", 64'(rd_log[1]), 64'hC0220044);
        chk("r1_beat3", 64'(rd_log[3]), 64'hC0DE0043);
        chk("r1_nlast", 64'(n_rlast), 64'd1);
        chk("r1_fetch_end", 64'(last_fetch_a), 64'h43);

        // Single beat held with RREADY low for five cycles.
        rd_log.delete();
        do_read(8'h22, 32'h108, 4'd0, 2'b01, 1'b1);
        chk("r2_data", 64'(rd_log[0]), 64'hC0230045);

        // Short write burst: AWLEN=1 but WLAST on first beat.
        do_write(8'h23, 32'h200, 4'd1, 2'b01, 1, 32'hCAFEF00D, 4'hF);
        chk("w3_bresp", 64'(last_bresp), 64'd2);
        chk("w3_bid", 64'(last_bid), 64'h23);

        // AR and AW presented together: read first, write after.
        rd_log.delete();
        fork
            do_read(8'h31, 32'h200, 4'd0, 2'b01, 1'b0);
            do_write(8'h32, 32'h300, 4'd0, 2'b01, 1, 32'h0BADF00D, 4'hC);
        join
        chk("tie_read_data", 64'(rd_log[0]), 64'hCAFEF00D);
        chk("tie_aw_after_r", 64'(aw_cyc > rlast_cyc), 64'd1);
        chk("tie_bid", 64'(last_bid), 64'h32);

        // Address wrap at the top of the SRAM.
        rd_log.delete();
        do_read(8'h34, 32'h0000FFFC, 4'd1, 2'b01, 1'b0);
        chk("wrap_fetch", 64'(last_fetch_a), 64'h0);
        chk("wrap_beat0", 64'(rd_log[0]), 64'hC0DE3FFF);
        chk("wrap_beat1", 64'(rd_log[1]), 64'hC0DE0000);

        // FIXED burst.
        rd_log.delete();
        do_read(8'h41, 32'h400, 4'd1, 2'b00, 1'b0);
        chk("fixed_beats", 64'(rd_log.size()), 64'd2);
`ifdef AXI_SRAM_BURST_CHECK_EN
        chk("fixed_rresp", 64'(last_rresp), 64'd2);
        do_write(8'h42, 32'h400, 4'd0, 2'b10, 1, 32'h12345678, 4'hF);
        chk("fixed_bresp", 64'(last_bresp), 64'd2);
`else
        chk("fixed_rresp", 64'(last_rresp), 64'd0);
        chk("fixed_beat0", 64'(rd_log[0]), 64'hC0DE0100);
`endif

        // Reset pulsed in the middle of a stalled read.
        push_read_exp(8'h61, 14'h40, 4'd3, 1'b0);
        RREADY = 1'b0;
        ARID = 8'h61; ARADDR = 32'h100; ARLEN = 4'd3; ARBURST = 2'b01; ARVALID = 1'b1;
        wait_ready(1, "ar_timeout");
        ARVALID = 1'b0;
        wait_rvalid("rvalid_timeout");
        @(posedge ACLK);
        #3;
        ARESETn = 1'b0;
        #1;
        chk("rst_mid_outputs", 64'({RVALID, ARREADY, CS, WEB}), 64'({3'b0, 4'hF}));
        chk("rst_mid_rdata", 64'(RDATA), 64'd0);
        exp_r.delete();
        exp_sram.delete();
        @(negedge ACLK);
        ARESETn = 1'b1;
        RREADY  = 1'b1;
        @(posedge ACLK);
        #1;
        chk("rst_mid_idle", 64'({RVALID, ARREADY, AWREADY}), 64'b011);

        // Recovery after reset.
        rd_log.delete();
        do_read(8'h51, 32'h100, 4'd0, 2'b01, 1'b0);
        chk("recover_data", 64'(rd_log[0]), 64'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog");
    end
endmodule
